mult_share_arbiter: RTL and testbench

- Shares one sequential shift-add multiplier between two requesters using round-robin arbitration.
- Captures the winning requester's operands, pulses the multiplier start, and counts the multiplier's fixed latency.
- Samples the product and returns it to the granted requester with a one-cycle done pulse.
- Sits between requester logic and the multiplier, whose start/a/b it drives and whose p it reads.

---
 rtl/mult_share_arbiter_if.sv | 25 ++
 rtl/mult_share_arbiter.sv | 121 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arbiter_if.sv
// Requester and multiplier signal bundle for mult_share_arbiter.
interface mult_share_arbiter_if #(
  parameter int WIDTH = 4
);
  logic               req0, req1;
  logic [WIDTH-1:0]   a0, b0, a1, b1;
  logic               gnt0, gnt1, done0, done1;
  logic [2*WIDTH-1:0] result;
  logic               busy;
  logic               mult_start;
  logic [WIDTH-1:0]   mult_a, mult_b;
  logic [2*WIDTH-1:0] mult_p;

  // Arbiter side.
  modport slave (
    input  req0, a0, b0, req1, a1, b1, mult_p,
    output gnt0, gnt1, done0, done1, result, busy, mult_start, mult_a, mult_b
  );

  // Requester/multiplier environment side.
  modport master (
    output req0, a0, b0, req1, a1, b1, mult_p,
    input  gnt0, gnt1, done0, done1, result, busy, mult_start, mult_a, mult_b
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin share of one fixed-latency sequential multiplier between two
// requesters. Operands are captured on arbitration, the multiplier is started
// in ISSUE, and the product is sampled when the latency counter expires.
module mult_share_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MULT_LAT = 10
) (
  input  logic                 clk,
  input  logic                 clr,
  mult_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  localparam logic [7:0] CNT_LOAD = 8'(MULT_LAT - 1);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               last_gnt_q, last_gnt_d;
  logic               win_q, win_d;
  logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic               done0_q, done0_d, done1_q, done1_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               pick;

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    win_d      = win_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    result_d   = result_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    start_d    = 1'b0;
    // On a tie the requester that did not win last time goes next.
    pick       = (bus.req0 && bus.req1) ? ~last_gnt_q : bus.req1;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          win_d      = pick;
          last_gnt_d = pick;
          ma_d       = pick ? bus.a1 : bus.a0;
          mb_d       = pick ? bus.b1 : bus.b0;
          gnt0_d     = ~pick;
          gnt1_d     = pick;
          start_d    = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          // Product is valid this cycle; done pulses alongside the new result.
          result_d = bus.mult_p;
          done0_d  = ~win_q;
          done1_d  = win_q;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; clr wins over everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;
      win_q      <= 1'b0;
      ma_q       <= '0;
      mb_q       <= '0;
      result_q   <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      win_q      <= win_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      result_q   <= result_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.done0      = done0_q;
  assign bus.done1      = done1_q;
  assign bus.result     = result_q;
  assign bus.busy       = busy_q;
  assign bus.mult_start = start_q;
  assign bus.mult_a     = ma_q;
  assign bus.mult_b     = mb_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a fixed-latency multiplier model.
module tb_mult_share_arbiter;
  localparam int WIDTH    = 4;
  localparam int MULT_LAT = 10;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mult_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mult_share_arbiter #(.WIDTH(WIDTH), .MULT_LAT(MULT_LAT)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Multiplier model: product appears exactly MULT_LAT cycles after start,
  // a junk value otherwise so early/late sampling is visible.
  logic [MULT_LAT-1:0] pv = '0;
  logic [7:0]          pp [MULT_LAT];
  always @(posedge clk) begin
    pv <= {pv[MULT_LAT-2:0], bus.mult_start};
    pp[0] <= 8'(bus.mult_a) * 8'(bus.mult_b);
    for (int i = 1; i < MULT_LAT; i++) pp[i] <= pp[i-1];
  end
  assign bus.mult_p = pv[MULT_LAT-1] ? pp[MULT_LAT-1] : 8'hEE;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    bus.req0 = 0; bus.req1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
    step(); step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    do_clr();
    total++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.mult_start} !== 6'b0) begin
      bad++; $display("FAIL reset_ctl got=%b want=000000",
        {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.mult_start});
    end
    total++;
    if (bus.result !== 8'd0) begin bad++; $display("FAIL reset_result got=%0d want=0", bus.result); end
    total++;
    if ({bus.mult_a, bus.mult_b} !== 8'd0) begin
      bad++; $display("FAIL reset_ops got=%h want=00", {bus.mult_a, bus.mult_b});
    end
  endtask

  task automatic test_single();
    bus.req0 = 1; bus.a0 = 3; bus.b0 = 5;
    step();                                  // t+1
    total++;
    if ({bus.gnt0, bus.gnt1, bus.mult_start, bus.busy, bus.mult_a, bus.mult_b} !== {4'b1011, 4'd3, 4'd5}) begin
      bad++; $display("FAIL single_issue got=%b want=%b",
        {bus.gnt0, bus.gnt1, bus.mult_start, bus.busy, bus.mult_a, bus.mult_b}, {4'b1011, 4'd3, 4'd5});
    end
    bus.req0 = 0;
    for (int c = 2; c <= 11; c++) begin
      step();
      total++;
      if ({bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mult_start} !== 6'b100000) begin
        bad++; $display("FAIL single_wait c=t+%0d got=%b want=100000", c,
          {bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mult_start});
      end
    end
    step();                                  // t+12
    total++;
    if ({bus.done0, bus.done1, bus.busy} !== 3'b100 || bus.result !== 8'd15) begin
      bad++; $display("FAIL single_done got d0d1busy=%b res=%0d want=100 res=15",
        {bus.done0, bus.done1, bus.busy}, bus.result);
    end
    step();                                  // t+13
    total++;
    if (bus.done0 !== 1'b0 || bus.result !== 8'd15) begin
      bad++; $display("FAIL single_hold got done0=%b res=%0d want=0 res=15", bus.done0, bus.result);
    end
  endtask

  task automatic test_simultaneous();
    do_clr();
    bus.req0 = 1; bus.a0 = 2; bus.b0 = 7;
    bus.req1 = 1; bus.a1 = 4; bus.b1 = 4;
    step();                                  // t+1
    total++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      bad++; $display("FAIL simul_gnt0 got=%b want=10", {bus.gnt0, bus.gnt1});
    end
    bus.req0 = 0;
    repeat (11) step();                      // t+12
    total++;
    if ({bus.done0, bus.done1} !== 2'b10 || bus.result !== 8'd14) begin
      bad++; $display("FAIL simul_done0 got=%b res=%0d want=10 res=14", {bus.done0, bus.done1}, bus.result);
    end
    step();                                  // t+13
    total++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01 || bus.mult_a !== 4'd4 || bus.mult_b !== 4'd4) begin
      bad++; $display("FAIL simul_gnt1 got=%b a=%0d b=%0d want=01 a=4 b=4",
        {bus.gnt0, bus.gnt1}, bus.mult_a, bus.mult_b);
    end
    bus.req1 = 0;
    repeat (11) step();                      // t+24
    total++;
    if ({bus.done0, bus.done1} !== 2'b01 || bus.result !== 8'd16) begin
      bad++; $display("FAIL simul_done1 got=%b res=%0d want=01 res=16", {bus.done0, bus.done1}, bus.result);
    end
  endtask

  task automatic test_fairness();
    int gidx[$];
    int gcyc[$];
    int ndone = 0;
    bus.a0 = 5; bus.b0 = 6; bus.a1 = 7; bus.b1 = 8;
    bus.req0 = 1; bus.req1 = 1;
    for (int c = 1; c <= 75; c++) begin
      step();
      if (bus.gnt0 && bus.gnt1) begin
        total++; bad++; $display("FAIL fair_excl_gnt c=%0d got=11 want=one-hot", c);
      end
      if (bus.done0 && bus.done1) begin
        total++; bad++; $display("FAIL fair_excl_done c=%0d got=11 want=one-hot", c);
      end
      if (bus.gnt0 || bus.gnt1) begin
        gidx.push_back(bus.gnt1 ? 1 : 0);
        gcyc.push_back(c);
        if (gidx.size() == 6) begin bus.req0 = 0; bus.req1 = 0; end
      end
      if (bus.done0 || bus.done1) begin
        ndone++;
        total++;
        if (bus.result !== (bus.done0 ? 8'd30 : 8'd56)) begin
          bad++; $display("FAIL fair_result c=%0d done1=%b got=%0d want=%0d", c, bus.done1,
            bus.result, bus.done0 ? 30 : 56);
        end
      end
    end
    total++;
    if (gidx.size() != 6 || ndone != 6) begin
      bad++; $display("FAIL fair_count grants=%0d dones=%0d want=6/6", gidx.size(), ndone);
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (gidx[i] != (i % 2) || gcyc[i] != 1 + 12 * i) begin
          bad++; $display("FAIL fair_grant i=%0d got idx=%0d cyc=%0d want idx=%0d cyc=%0d",
            i, gidx[i], gcyc[i], i % 2, 1 + 12 * i);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.req1 = 1; bus.a1 = 9; bus.b1 = 9;
    step();                                  // t+1
    total++;
    if (bus.gnt1 !== 1'b1) begin bad++; $display("FAIL mid_gnt1 got=%b want=1", bus.gnt1); end
    bus.req1 = 0;
    repeat (5) step();                       // t+6
    clr = 1'b1;
    step();                                  // t+7
    clr = 1'b0;
    total++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.mult_start} !== 6'b0 ||
        bus.result !== 8'd0 || {bus.mult_a, bus.mult_b} !== 8'd0) begin
      bad++; $display("FAIL mid_clr got ctl=%b res=%0d ops=%h want all 0",
        {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.mult_start}, bus.result,
        {bus.mult_a, bus.mult_b});
    end
    for (int c = 8; c <= 16; c++) begin
      step();
      total++;
      if ({bus.done0, bus.done1, bus.busy} !== 3'b0) begin
        bad++; $display("FAIL mid_no_done c=t+%0d got=%b want=000", c, {bus.done0, bus.done1, bus.busy});
      end
    end
    bus.req1 = 1; bus.a1 = 15; bus.b1 = 15;  // s
    step();                                  // s+1
    total++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      bad++; $display("FAIL mid_regnt got=%b want=01", {bus.gnt0, bus.gnt1});
    end
    bus.req1 = 0;
    repeat (11) step();                      // s+12
    total++;
    if (bus.done1 !== 1'b1 || bus.result !== 8'd225) begin
      bad++; $display("FAIL mid_max got done1=%b res=%0d want=1 res=225", bus.done1, bus.result);
    end
  endtask

  task automatic test_late_request();
    bus.req0 = 1; bus.a0 = 2; bus.b0 = 2;    // t
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) bus.req0 = 0;
      if (c == 4) begin bus.req1 = 1; bus.a1 = 6; bus.b1 = 3; end
      total++;
      if (bus.gnt1 !== 1'b0) begin bad++; $display("FAIL late_early_gnt1 c=t+%0d got=1 want=0", c); end
    end
    total++;
    if (bus.done0 !== 1'b1 || bus.result !== 8'd4) begin
      bad++; $display("FAIL late_done0 got done0=%b res=%0d want=1 res=4", bus.done0, bus.result);
    end
    step();                                  // t+13
    total++;
    if (bus.gnt1 !== 1'b1 || bus.mult_a !== 4'd6 || bus.mult_b !== 4'd3) begin
      bad++; $display("FAIL late_gnt1 got gnt1=%b a=%0d b=%0d want=1 a=6 b=3", bus.gnt1, bus.mult_a, bus.mult_b);
    end
    bus.req1 = 0; bus.a1 = 1; bus.b1 = 1;    // must not disturb the in-flight op
    repeat (11) step();                      // t+24
    total++;
    if (bus.done1 !== 1'b1 || bus.result !== 8'd18) begin
      bad++; $display("FAIL late_done1 got done1=%b res=%0d want=1 res=18", bus.done1, bus.result);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_reset_mid();
    test_late_request();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
